// File: rtl/pcla_sub16.sv
// Pipelined parallel-prefix (kill/propagate/generate) subtractor, diff = a - b.
// One prefix level per pipeline stage, with a valid/ready handshake so the
// pipeline streams one operation per cycle and freezes as a whole under backpressure.
module pcla_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    // Number of prefix levels, always log2(WIDTH).
    localparam int STAGES = $clog2(WIDTH);
    localparam int MSB    = WIDTH - 1;

    // kpg encoding: 00 kill, 01/10 propagate, 11 generate.
    typedef logic [1:0] kpg_t;
    localparam kpg_t KPG_GEN = 2'b11;

    function automatic logic is_prop(input kpg_t k);
        return k[1] ^ k[0];
    endfunction

    // Prefix position p holds the kpg of bit p-1; position 0 is the
    // carry-in seed (generate, giving the +1 of a + ~b + 1). After all
    // levels, position i is the resolved carry into bit i.
    kpg_t             kpg_in [WIDTH];

    // Stage s register holds the prefix vector after s levels.
    kpg_t             pfx_q  [STAGES][WIDTH];
    kpg_t             pfx_d  [STAGES][WIDTH];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] nb_q   [STAGES];
    logic [STAGES-1:0] vld_q;

    logic             advance;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_d;
    kpg_t             kpg_msb;
    logic             carry_out;
    logic             zero_d;
    logic             ovf_d;

    // The whole pipeline moves in lockstep: it only holds when a result is
    // waiting and the consumer does not take it.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Per-bit kpg of a + ~b, shifted up by one behind the carry-in seed.
    always_comb begin
        kpg_in[0] = KPG_GEN;
        for (int i = 1; i < WIDTH; i++) begin
            kpg_in[i] = {a[i-1], ~b[i-1]};
        end
    end

    // Prefix level s applied to the stage-s register: a propagating
    // position inherits the group value 2^s positions below it.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            for (int i = 0; i < WIDTH; i++) begin
                pfx_d[s][i] = pfx_q[s][i];
            end
            for (int i = (1 << s); i < WIDTH; i++) begin
                if (is_prop(pfx_q[s][i])) begin
                    pfx_d[s][i] = pfx_q[s][i - (1 << s)];
                end
            end
        end
    end

    // Final stage: sum bits, carry-out from the MSB, and the result flags.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            carry[i] = (pfx_d[STAGES-1][i] == KPG_GEN);
        end
        diff_d    = a_q[STAGES-1] ^ nb_q[STAGES-1] ^ carry;
        kpg_msb   = {a_q[STAGES-1][MSB], nb_q[STAGES-1][MSB]};
        carry_out = is_prop(kpg_msb) ? carry[MSB] : kpg_msb[1];
        zero_d    = (diff_d == '0);
        // Operand signs differ exactly when a[MSB] equals ~b[MSB].
        ovf_d     = (a_q[STAGES-1][MSB] == nb_q[STAGES-1][MSB]) &&
                    (diff_d[MSB] != a_q[STAGES-1][MSB]);
    end

    // Pipeline registers: reset clears everything, otherwise all stages load together on advance.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every stage sample the previous
        // stage's old value on the same edge; blocking ones would collapse the pipeline.
        if (reset) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]  <= '0;
                nb_q[s] <= '0;
                for (int i = 0; i < WIDTH; i++) begin
                    pfx_q[s][i] <= '0;
                end
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            a_q[0]   <= a;
            nb_q[0]  <= ~b;
            for (int i = 0; i < WIDTH; i++) begin
                pfx_q[0][i] <= kpg_in[i];
            end
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                a_q[s]   <= a_q[s-1];
                nb_q[s]  <= nb_q[s-1];
                for (int i = 0; i < WIDTH; i++) begin
                    pfx_q[s][i] <= pfx_d[s-1][i];
                end
            end
            out_valid <= vld_q[STAGES-1];
            diff      <= diff_d;
            borrow    <= ~carry_out;
            zero      <= zero_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pcla_sub16.sv
// Self-checking bench for pcla_sub16: table-driven single ops with latency
// checks, a back-to-back stream, a backpressure stall and a mid-flight reset.
module tb_pcla_sub16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;

    pcla_sub16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] diff;
        logic        borrow;
        logic        zero;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        br;
        logic        z;
        logic        o;
    } res_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    res_t exp_q[$];
    int   acc_log[$];
    int   out_log[$];
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
        res_t r;
        r.d  = x - y;
        r.br = (x < y);
        r.z  = (r.d == 16'h0000);
        r.o  = (x[15] != y[15]) && (r.d[15] != x[15]);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard on the falling edge: inputs and outputs are stable here and
    // show what the next rising edge will do.
    logic held_stall = 1'b0;
    res_t held_val;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held_stall = 1'b0;
        end else begin
            res_t got;
            got = '{d: diff, br: borrow, z: zero, o: ovf};
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, ~(out_valid & ~out_ready)});
            if (held_stall) begin
                check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold_data", {13'd0, got}, {13'd0, held_val});
            end
            held_stall = out_valid & ~out_ready;
            held_val   = got;
            if (out_valid & ~out_ready) stall_cnt++;
            if (out_valid & out_ready) begin
                out_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_result", {13'd0, got}, {13'd0, e});
                end
            end
            if (in_valid & in_ready) begin
                acc_log.push_back(cyc);
                exp_q.push_back(model(a, b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Issue one op with an empty pipeline, measure latency, compare against the table.
    task automatic run_one(input vec_t v, input string tag);
        int lat;
        a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_diff"}, {16'd0, diff}, {16'd0, v.diff});
        check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, v.borrow});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, v.zero});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    endtask

    // Hold an op on the inputs until the edge that accepts it.
    task automatic send(input logic [15:0] x, input logic [15:0] y);
        logic ok;
        int   tries;
        a = x; b = y; in_valid = 1'b1;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            tries++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{16'h1000, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0};

        // Reset state
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff", {16'd0, diff}, 32'd0);
        check("rst_flags", {29'd0, borrow, zero, ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end
        repeat (3) @(posedge clk); #1;

        // Back-to-back stream, out_ready held high
        acc_log.delete(); out_log.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            if (k == 3) b = a;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("stream_count", out_log.size(), 16);
        if (out_log.size() == 16 && acc_log.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                check($sformatf("stream_cycle%0d", k), out_log[k], acc_log[0] + 5 + k);
            end
        end
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: drop out_ready for 3 cycles mid-stream
        acc_log.delete(); out_log.delete(); stall_cnt = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 12; k++) send(16'($urandom), 16'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk); #1;
        check("bp_stall_cycles", stall_cnt, 3);
        check("bp_accepted", acc_log.size(), 12);
        check("bp_delivered", out_log.size(), 12);
        check("bp_drained", exp_q.size(), 0);

        // Reset with 3 ops in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 16'h4000 + 16'(k); b = 16'h0001; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_diff", {16'd0, diff}, 32'd0);
        check("rst2_flags", {29'd0, borrow, zero, ovf}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst2_no_stale%0d", k), {31'd0, out_valid}, 32'd0);
        end
        run_one(vecs[2], "post_rst");
        repeat (3) @(posedge clk); #1;
        check("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
